// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient} for the HI/LO write.
// Signed operands are divided as magnitudes, and the signs are restored when the result is written.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               busy,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   dvd_q,    dvd_d;
  logic [WIDTH-1:0]   dvs_q,    dvs_d;
  logic               negq_q,   negq_d;
  logic               negr_q,   negr_d;
  logic               busy_q,   busy_d;
  logic               valid_q,  valid_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_lo, diff, rem_next, dvd_next, q_fin, r_fin;
  logic               take;

  assign op1_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign op2_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // The shifted remainder can reach WIDTH+1 bits; when its top bit is set,
  // the trial subtraction cannot borrow, and the WIDTH-bit difference is exact.
  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign rem_lo   = rem_sh[WIDTH-1:0];
  assign diff     = rem_lo - dvs_q;
  assign take     = rem_sh[WIDTH] | (rem_lo >= dvs_q);
  assign rem_next = take ? diff : rem_lo;
  assign dvd_next = {dvd_q[WIDTH-2:0], take};
  assign q_fin    = negq_q ? -dvd_next : dvd_next;
  assign r_fin    = negr_q ? -rem_next : rem_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CALC;
            dvd_d   = op1_abs;
            dvs_d   = op2_abs;
            negq_d  = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            negr_d  = signed_div & opdata1[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
        CALC: begin
          rem_d = rem_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = {r_fin, q_fin};
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operands against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        annul = 1'b0;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] last_exp = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .annul        (annul),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: divide magnitudes, x/0 gives all-ones quotient and the dividend as remainder.
  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    bit na, nb;
    na = sg && a[31];
    nb = sg && b[31];
    ua = na ? (32'd0 - a) : a;
    ub = nb ? (32'd0 - b) : b;
    if (ub == 32'd0) begin
      q = '1;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (na ^ nb) q = 32'd0 - q;
    if (na)      r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic run_op(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp        = ref_div(sg, a, b);
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    opdata1    = $urandom;
    opdata2    = $urandom;
    for (int k = 1; k <= 40; k++) begin
      check_eq({tag, "_busy"},  64'(busy),         64'(k <= 32));
      check_eq({tag, "_valid"}, 64'(result_valid), 64'(k == 33));
      if (k == 33) check_eq({tag, "_res"},  result, exp);
      if (k == 40) check_eq({tag, "_hold"}, result, exp);
      tick();
    end
    last_exp = exp;
  endtask

  initial begin
    tick();
    check_eq("rst_busy",  64'(busy),         64'd0);
    check_eq("rst_valid", 64'(result_valid), 64'd0);
    check_eq("rst_res",   result,            64'd0);
    resetn = 1'b1;
    tick();

    run_op("u100_7",   1'b0, 32'd100,         32'd7);
    check_eq("u100_7_const", last_exp, {32'h2, 32'hE});
    run_op("s-7_2",    1'b1, 32'hFFFFFFF9,    32'd2);
    run_op("s7_-2",    1'b1, 32'd7,           32'hFFFFFFFE);
    run_op("s-7_-2",   1'b1, 32'hFFFFFFF9,    32'hFFFFFFFE);
    run_op("s_ovf",    1'b1, 32'h80000000,    32'hFFFFFFFF);
    run_op("u_ovf",    1'b0, 32'h80000000,    32'hFFFFFFFF);
    run_op("u5_0",     1'b0, 32'd5,           32'd0);
    run_op("s-7_0",    1'b1, 32'hFFFFFFF9,    32'd0);

    // start together with annul in IDLE must not launch an operation
    signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd3;
    start = 1'b1; annul = 1'b1;
    tick();
    start = 1'b0; annul = 1'b0;
    check_eq("stannul_busy", 64'(busy), 64'd0);
    tick();
    check_eq("stannul_valid", 64'(result_valid), 64'd0);
    check_eq("stannul_res",   result,            last_exp);

    // Cancel 50/5 at T+10, re-issue 9/4 at T+11, stray start at T+20
    signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      check_eq("cx_busy",  64'(busy),         64'((k <= 10) || (k >= 12 && k <= 43)));
      check_eq("cx_valid", 64'(result_valid), 64'(k == 44));
      if (k == 11) check_eq("cx_keep", result, last_exp);
      if (k == 44 || k == 50) check_eq("cx_res", result, {32'd1, 32'd2});
      annul = (k == 10);
      start = (k == 11) || (k == 20);
      if (k == 11) begin signed_div = 1'b0; opdata1 = 32'd9;    opdata2 = 32'd4; end
      if (k == 20) begin signed_div = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd3; end
      tick();
    end
    start = 1'b0; annul = 1'b0;
    last_exp = {32'd1, 32'd2};

    // Asynchronous reset in the middle of an operation
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 resetn = 1'b0;
    #1;
    check_eq("amid_busy",  64'(busy),         64'd0);
    check_eq("amid_valid", 64'(result_valid), 64'd0);
    check_eq("amid_res",   result,            64'd0);
    #3 resetn = 1'b1;
    run_op("post_rst", 1'b0, 32'd1000, 32'd7);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      bit sg;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = 32'd0 - 32'($urandom_range(1, 15));
        3:       begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 300)); end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("rnd", sg, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
